// File: rtl/serial_byte_receiver_pkg.sv
// Shared definitions for the serial byte link: FSM state encoding and line levels.
// The transmitter imports the same package so both ends agree on framing.
package serial_byte_receiver_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2,
        S_RSVD = 2'd3
    } rx_state_t;

    localparam int   DEFAULT_DATA_WIDTH = 8;
    localparam logic LINE_IDLE_LEVEL    = 1'b1;
    localparam logic START_BIT_LEVEL    = 1'b0;
    localparam logic STOP_BIT_LEVEL     = 1'b1;

endpackage

// File: rtl/serial_byte_receiver_sipo_shift_reg.sv
// W-bit serial-in/parallel-out register; dir=1 shifts toward the MSB, dir=0 toward the LSB.
module sipo_shift_reg #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         shift_en,
    input  logic         dir,
    input  logic         din,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_reg <= '0;
        end else if (shift_en) begin
            if (dir) begin
                q_reg <= {q_reg[W-2:0], din};
            end else begin
                q_reg <= {din, q_reg[W-1:1]};
            end
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/serial_byte_receiver.sv
// Receive end of the serial byte link: start/data/stop framing sampled on BitTick,
// valid/ack handshake on the parallel side, sticky framing and overrun flags.
module serial_byte_receiver
    import serial_byte_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  BitTick,
    input  logic                  SerialIn,
    input  logic                  DataAck,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  FrameError,
    output logic                  Overrun,
    output logic                  Busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    rx_state_t               state_reg, state_next;
    logic [CW-1:0]           count_reg, count_next;
    logic [DATA_WIDTH-1:0]   data_out_reg;
    logic                    data_valid_reg;
    logic                    frame_error_reg;
    logic                    overrun_reg;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    shift_en;
    logic                    good_done;
    logic                    bad_done;

    sipo_shift_reg #(.W(DATA_WIDTH)) u_shift (
        .Clock    (Clock),
        .Reset    (Reset),
        .shift_en (shift_en),
        .dir      (MSB_FIRST),
        .din      (SerialIn),
        .q        (shift_q)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shift_en   = 1'b0;
        good_done  = 1'b0;
        bad_done   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (BitTick && SerialIn == START_BIT_LEVEL) begin
                    state_next = S_DATA;
                    count_next = '0;
                end
            end
            S_DATA: begin
                if (BitTick) begin
                    shift_en   = 1'b1;
                    count_next = count_reg + CW'(1);
                    if (count_reg == LAST_BIT) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (BitTick) begin
                    state_next = S_IDLE;
                    good_done  = (SerialIn == STOP_BIT_LEVEL);
                    bad_done   = (SerialIn != STOP_BIT_LEVEL);
                end
            end
            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // A good completion wins over an ack in the same cycle, so the new byte stays valid.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_out_reg    <= '0;
            data_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else if (good_done) begin
            data_out_reg    <= shift_q;
            data_valid_reg  <= 1'b1;
            frame_error_reg <= 1'b0;
            if (data_valid_reg && !DataAck) begin
                overrun_reg <= 1'b1;
            end
        end else begin
            if (bad_done) begin
                frame_error_reg <= 1'b1;
            end
            if (DataAck) begin
                data_valid_reg <= 1'b0;
            end
        end
    end

    assign DataOut    = data_out_reg;
    assign DataValid  = data_valid_reg;
    assign FrameError = frame_error_reg;
    assign Overrun    = overrun_reg;
    assign Busy       = (state_reg == S_DATA) || (state_reg == S_STOP);

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Frame-level model of the receiver, checked every cycle against an LSB-first and an MSB-first instance.
module tb_serial_byte_receiver;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       BitTick = 1'b0;
    logic       SerialIn = 1'b1;
    logic       DataAck = 1'b0;

    logic [7:0] out_l, out_m;
    logic       valid_l, ferr_l, ovr_l, busy_l;
    logic       valid_m, ferr_m, ovr_m, busy_m;

    logic [7:0] exp_lsb = 8'h00;
    logic [7:0] exp_msb = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr = 1'b0;
    logic       exp_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_byte_receiver #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .Clock(clk), .Reset(Reset), .BitTick(BitTick), .SerialIn(SerialIn), .DataAck(DataAck),
        .DataOut(out_l), .DataValid(valid_l), .FrameError(ferr_l), .Overrun(ovr_l), .Busy(busy_l)
    );

    serial_byte_receiver #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .Clock(clk), .Reset(Reset), .BitTick(BitTick), .SerialIn(SerialIn), .DataAck(DataAck),
        .DataOut(out_m), .DataValid(valid_m), .FrameError(ferr_m), .Overrun(ovr_m), .Busy(busy_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    // Per-cycle comparison of both instances against the frame-level model.
    always @(posedge clk) begin
        #1;
        check("cyc_data_lsb", out_l, exp_lsb);
        check("cyc_data_msb", out_m, exp_msb);
        check("cyc_valid", {valid_l, valid_m}, {exp_valid, exp_valid});
        check("cyc_ferr", {ferr_l, ferr_m}, {exp_ferr, exp_ferr});
        check("cyc_ovr", {ovr_l, ovr_m}, {exp_ovr, exp_ovr});
        check("cyc_busy", {busy_l, busy_m}, {exp_busy, exp_busy});
    end

    task automatic drive(input logic t, input logic s, input logic a);
        @(negedge clk);
        BitTick = t;
        SerialIn = s;
        DataAck = a;
    endtask

    task automatic gap(input int n, input bit wiggle);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, wiggle ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
        end
    endtask

    // kind: 0 start bit, 1 data bit, 2 stop bit
    task automatic period(input logic s, input logic ack, input int kind, input logic [7:0] d);
        gap(3, 1'b0);
        drive(1'b1, s, ack);
        if (kind == 0) exp_busy = 1'b1;
        if (kind == 2) exp_busy = 1'b0;
        if (kind == 2 && s) begin
            if (exp_valid && !ack) exp_ovr = 1'b1;
            exp_lsb = d;
            exp_msb = rev8(d);
            exp_valid = 1'b1;
            exp_ferr = 1'b0;
        end else begin
            if (kind == 2) exp_ferr = 1'b1;
            if (ack) exp_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_stop,
                              input bit pause);
        period(1'b0, 1'b0, 0, d);
        for (int i = 0; i < 8; i++) begin
            if (pause && i == 4) gap(50, 1'b1);
            period(d[i], 1'b0, 1, d);
        end
        period(stop, ack_stop, 2, d);
        @(posedge clk);
        #2;
        $display("frame %02h stop=%0b ack=%0b -> lsb=%02h msb=%02h v=%0b fe=%0b ov=%0b",
                 d, stop, ack_stop, out_l, out_m, valid_l, ferr_l, ovr_l);
    endtask

    task automatic ack_cycle();
        drive(1'b0, 1'b1, 1'b1);
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1;
        BitTick = 1'b0;
        SerialIn = 1'b1;
        DataAck = 1'b0;
        exp_lsb = 8'h00; exp_msb = 8'h00;
        exp_valid = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0; exp_busy = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
        check("rst_data", {out_l, out_m}, 16'h0000);
        check("rst_flags", {valid_l, ferr_l, ovr_l, busy_l}, 4'b0000);

        // Bit orderings
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check("a5_lsb", out_l, 8'hA5);
        check("a5_msb", out_m, 8'hA5);
        check("a5_valid_ferr", {valid_l, ferr_l}, 2'b10);
        ack_cycle();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check("3c_lsb", out_l, 8'h3C);
        check("3c_msb", out_m, 8'h3C);
        ack_cycle();
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        check("01_lsb", out_l, 8'h01);
        check("01_msb", out_m, 8'h80);
        ack_cycle();

        // Framing error and recovery
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        ack_cycle();
        send_frame(8'hE7, 1'b0, 1'b0, 1'b0);
        check("bad_stop_ferr", ferr_l, 1'b1);
        check("bad_stop_data", out_l, 8'h5A);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        check("c3_ferr_clear", ferr_l, 1'b0);
        check("c3_data", out_l, 8'hC3);

        // Overrun without ack, then same-cycle ack avoids it
        do_reset();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        check("ovr_set", {ovr_l, valid_l}, 2'b11);
        check("ovr_data", {out_l, out_m}, {8'h22, 8'h44});
        do_reset();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        check("ack_same_cycle", {ovr_l, valid_l}, 2'b01);
        ack_cycle();
        ack_cycle();
        check("ack_idle", valid_l, 1'b0);

        // Reset mid-frame aborts it
        period(1'b0, 1'b0, 0, 8'h00);
        for (int i = 0; i < 4; i++) period(1'b1, 1'b0, 1, 8'h00);
        do_reset();
        #1;
        check("midrst_out", {out_l, valid_l, ferr_l, ovr_l, busy_l}, 12'h000);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        check("ff_data", {out_l, out_m}, 16'hFFFF);
        ack_cycle();

        // Long tick pause with a wiggling line mid-frame
        send_frame(8'h96, 1'b1, 1'b0, 1'b1);
        check("96_data", {out_l, out_m}, {8'h96, 8'h69});
        check("96_flags", {valid_l, ferr_l, busy_l}, 3'b100);

        gap(4, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
